// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency valid/ready word memory with reset-time preload and live view.
// Define DMEM_MISALIGN_CHECK_EN to reject accesses whose byte offset is non-zero with resp_err.
module data_memory_responder #(
  parameter int DEPTH = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] initial_values [DEPTH],
  output logic [31:0] memory_check [DEPTH]
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic wr_q;
  logic [IW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic [31:0] mem [DEPTH];
  logic bad, accept, access, unused_addr;
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  assign access = state == BUSY && cnt == 4'd0;
  assign memory_check = mem;
`ifdef DMEM_MISALIGN_CHECK_EN
  logic [1:0] off_q;
  assign unused_addr = ^req_addr[31:IW+2];
  assign bad = off_q != 2'b00;
  always_ff @(posedge clk) begin
    if (accept) off_q <= req_addr[1:0];
    if (reset) resp_err <= 1'b0;
    else if (access) resp_err <= bad;
  end
`else
  assign unused_addr = ^{req_addr[31:IW+2], req_addr[1:0]};
  assign bad = 1'b0;
  assign resp_err = 1'b0;
`endif
  always_comb
    state_nx = state == IDLE ? (req_valid ? BUSY : IDLE) :
               state == BUSY ? (cnt == 4'd0 ? RESP : BUSY) :
               (resp_ready ? IDLE : RESP);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      resp_rdata <= 32'd0;
      mem <= initial_values;
    end else begin
      state <= state_nx;
      if (accept) begin
        wr_q <= req_write;
        idx_q <= req_addr[IW+1:2];
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        cnt <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        resp_rdata <= (wr_q || bad) ? 32'd0 : mem[idx_q];
        if (wr_q && !bad)
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed vector table, corner sequences and random traffic against an array model.
module tb_data_memory_responder;
  localparam int DEPTH = 32;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0] req_wstrb;
  logic [31:0] init [DEPTH];
  logic [31:0] mc [DEPTH];
  logic [31:0] mm [DEPTH];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .initial_values(init), .memory_check(mc)
  );
  typedef struct {
    logic w; logic [31:0] a; logic [31:0] wd; logic [3:0] s; int hold;
    logic [31:0] erd; logic eer; int widx; logic [31:0] eword;
  } vec_t;
  vec_t tv [8];
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_diff(input logic [31:0] ref_mem [DEPTH]);
    logic [31:0] n = 0;
    for (int i = 0; i < DEPTH; i++) if (mc[i] !== ref_mem[i]) n++;
    return n;
  endfunction
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] s, output logic [31:0] rd, output logic er);
    int i = int'((a >> 2) % DEPTH);
    rd = 0;
    er = 0;
`ifdef DMEM_MISALIGN_CHECK_EN
    er = a[1:0] != 2'b00;
`endif
    if (!er && !w) rd = mm[i];
    if (!er && w) for (int b = 0; b < 4; b++) if (s[b]) mm[i][8*b +: 8] = wd[8*b +: 8];
  endfunction
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s,
                      input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] erd, snap;
    logic eer;
    int idx = int'((a >> 2) % DEPTH);
    model(w, a, wd, s, erd, eer);
    chk("ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = s;
    step;
    req_valid = 0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    for (int c = 0; c < LAT; c++) begin
      chk("busy_valid", 32'(resp_valid), 0);
      chk("busy_ready", 32'(req_ready), 0);
      step;
    end
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_rdata", resp_rdata, erd);
    chk("resp_err", 32'(resp_err), 32'(eer));
    chk("mem_word", mc[idx], mm[idx]);
    snap = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1; req_write = 1; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'hF;
      step;
      chk("hold_valid", 32'(resp_valid), 1);
      chk("hold_rdata", resp_rdata, snap);
      chk("hold_ready", 32'(req_ready), 0);
    end
    rd = resp_rdata;
    er = resp_err;
    req_valid = 0;
    resp_ready = 1;
    step;
    resp_ready = 0;
    chk("post_valid", 32'(resp_valid), 0);
    chk("post_ready", 32'(req_ready), 1);
    chk("post_mem", mem_diff(mm), 0);
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    int acc [$];
    for (int i = 0; i < DEPTH; i++) init[i] = 32'hC0DE_0000 + 32'(i);
    init[3] = 32'hDEADBEEF;
    init[4] = 32'hAABBCCDD;
    mm = init;
    tv[0] = '{0, 32'h0C, 0, 0, 5, 32'hDEADBEEF, 0, 3, 32'hDEADBEEF};
    tv[1] = '{1, 32'h10, 32'h11223344, 4'b0101, 0, 0, 0, 4, 32'hAA22CC44};
    tv[2] = '{0, 32'h10, 0, 0, 1, 32'hAA22CC44, 0, 4, 32'hAA22CC44};
    tv[3] = '{0, 32'h84, 0, 0, 0, 32'hC0DE0001, 0, 1, 32'hC0DE0001};
`ifdef DMEM_MISALIGN_CHECK_EN
    tv[4] = '{1, 32'h06, 32'h12345678, 4'hF, 0, 0, 1, 1, 32'hC0DE0001};
    tv[5] = '{0, 32'h04, 0, 0, 0, 32'hC0DE0001, 0, 1, 32'hC0DE0001};
`else
    tv[4] = '{1, 32'h06, 32'h12345678, 4'hF, 0, 0, 0, 1, 32'h12345678};
    tv[5] = '{0, 32'h04, 0, 0, 0, 32'h12345678, 0, 1, 32'h12345678};
`endif
    tv[6] = '{1, 32'h14, 32'hFFFFFFFF, 4'h0, 2, 0, 0, 5, 32'hC0DE0005};
    tv[7] = '{0, 32'h14, 0, 0, 0, 32'hC0DE0005, 0, 5, 32'hC0DE0005};
    reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; resp_ready = 0;
    step; step;
    reset = 0;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_mem", mem_diff(init), 0);
    for (int i = 0; i < 8; i++) begin
      xact(tv[i].w, tv[i].a, tv[i].wd, tv[i].s, tv[i].hold, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].erd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].eer));
      chk($sformatf("vec%0d_word", i), mc[tv[i].widx], tv[i].eword);
    end
    // back-to-back loads with both valids held high: accepts every LAT+2 edges
    req_valid = 1; req_write = 0; req_addr = 0; resp_ready = 1;
    for (int n = 0; n < 20; n++) begin
      if (req_ready && req_valid) acc.push_back(n);
      step;
    end
    req_valid = 0;
    for (int n = 0; n < LAT + 3; n++) step;
    resp_ready = 0;
    chk("tput_count", 32'(acc.size() >= 3), 1);
    if (acc.size() >= 3) begin
      chk("tput_gap0", 32'(acc[1] - acc[0]), LAT + 2);
      chk("tput_gap1", 32'(acc[2] - acc[1]), LAT + 2);
    end
    // reset while the store to word 2 is in flight must drop it
    req_valid = 1; req_write = 1; req_addr = 32'h08; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
    step;
    req_valid = 0;
    reset = 1;
    step; step;
    reset = 0;
    mm = init;
    chk("rstb_ready", 32'(req_ready), 1);
    chk("rstb_word2", mc[2], init[2]);
    chk("rstb_mem", mem_diff(init), 0);
    for (int n = 0; n < LAT + 2; n++) begin
      chk("rstb_novalid", 32'(resp_valid), 0);
      step;
    end
    chk("rstb_word2_late", mc[2], init[2]);
    for (int n = 0; n < 40; n++)
      xact(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)), rd, er);
    chk("final_mem", mem_diff(mm), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Handshaked data-memory responder for the RV32I core's load/store port. It accepts one word-wide read or write request at a time over a valid/ready request channel. It performs the access after a fixed, parameterised latency and returns the result on a valid/ready response channel. It replaces the zero-latency combinational data memory when the core is built as a multi-cycle initiator, and keeps the same reset-time preload and debug-visibility array ports.

## Interface

- DEPTH, 32, number of 32-bit words; power of two, 2..256
- LATENCY, 2, cycles from request acceptance to response valid; 1..15

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_wstrb  in  4  byte enables for stores; bit i enables byte i = bits [8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  initiator accepts response
- resp_rdata  out  32  load data; 0 for stores
- resp_err  out  1  access error (see Configuration)
- initial_values  in  32 x [DEPTH]  words loaded into memory while reset is high
- memory_check  out  32 x [DEPTH]  live view of every memory word, combinational from the array

## Operation

- States: IDLE, BUSY, RESP.
- req_ready = (state == IDLE). resp_valid = (state == RESP). Both are decoded from registered state only; there is no combinational path from any input to either.
- Word index = req_addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH.
- IDLE: on a clock edge with req_valid && req_ready:
  - latch write, index, addr[1:0], wdata and wstrb;
  - set cnt <= LATENCY-1;
  - go to BUSY.
- BUSY with cnt != 0: cnt <= cnt-1.
- BUSY with cnt == 0: perform the access and go to RESP.
  - Load: resp_rdata <= mem[index].
  - Store: update each enabled byte of mem[index]; resp_rdata <= 0.
  - wstrb == 0 store: memory unchanged, normal response.
- RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready is high at an edge, then go to IDLE. A request presented during RESP is not accepted.
- Only one transaction is outstanding at a time. There is no pipelining and no request buffering.
- Request-side signals are sampled only at the accept edge. Later changes while in BUSY or RESP have no effect.

## Timing

- Reset, synchronous. While reset is high, at each edge:
  - state <= IDLE, cnt <= 0, resp_rdata <= 0, resp_err <= 0;
  - mem[i] <= initial_values[i] for all i.
- Output values after reset: req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, memory_check = initial_values.
- Reset during BUSY or RESP drops the transaction. A store not yet committed is never committed.
- If acceptance is at edge T, resp_valid rises after edge T+LATENCY. A store becomes visible on memory_check after the same edge.
- The response handshake at edge R makes req_ready high after R. The earliest next accept is edge R+1.
- Back-to-back throughput is one transaction per LATENCY+2 cycles when resp_ready is held high.
- resp_valid stays asserted for at least one cycle, with stable data, regardless of resp_ready.

## Configuration

- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Any access with latched addr[1:0] != 0 leaves memory unchanged and returns resp_err = 1 and resp_rdata = 0.
  - Latency and handshake are identical to a normal access.
  - Aligned accesses return resp_err = 0.
- Undefined:
  - addr[1:0] is ignored and the access proceeds on the word index.
  - resp_err is constant 0; its register may be optimised away.

## Test plan

- LATENCY=2, initial_values[3]=0xDEADBEEF; load addr 0x0C accepted at edge T -> resp_valid after T+2, resp_rdata=0xDEADBEEF, resp_err=0.
- Store addr 0x10, wdata 0x11223344, wstrb 4'b0101 over initial word 0xAABBCCDD -> memory_check[4]=0xAA22CC44 after T+LATENCY, resp_rdata=0. A following load of 0x10 returns 0xAA22CC44.
- Hold resp_ready=0 for 5 cycles during RESP -> resp_valid and resp_rdata stable, req_ready=0, and a second req_valid is not accepted. Release -> req_ready=1 next cycle.
- Assert reset one cycle after accepting a store to addr 0x08 (LATENCY=3) -> memory_check[2] equals initial_values[2], resp_valid never rises, req_ready=1 after reset.
- With DMEM_MISALIGN_CHECK_EN, store to addr 0x06 -> resp_err=1 and memory unchanged. Without the macro, the same store writes word 1 and resp_err=0.
- DEPTH=32, load addr 0x84 -> returns mem[1] (wrap-around).
